// File: rtl/pit_pkg.sv
// Shared types, constants and access-sequencing helpers for the PIT bus master.
package pit_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        GAP,
        FINISH
    } pit_state_e;

    // Control-word register address
    localparam logic [1:0] A_CTRL = 2'b11;

    // RW field codes
    localparam logic [1:0] RW_LATCH = 2'b00;
    localparam logic [1:0] RW_LSB   = 2'b01;
    localparam logic [1:0] RW_MSB   = 2'b10;
    localparam logic [1:0] RW_BOTH  = 2'b11;

    // Request captured at acceptance
    typedef struct packed {
        logic               op;
        logic [1:0]         sel;
        logic [1:0]         rw_mode;
        logic [2:0]         mode;
        logic               bcd;
        logic [COUNT_W-1:0] count;
    } pit_req_t;

    // One bus access derived from a request
    typedef struct packed {
        logic              write;
        logic [1:0]        addr;
        logic [DATA_W-1:0] data;
        logic              msb;
    } pit_acc_t;

    // Number of bus accesses a legal request needs
    function automatic logic [IDX_W-1:0] acc_total(input pit_req_t req);
        logic [IDX_W-1:0] n;
        if (req.op) begin
            n = (req.rw_mode == RW_BOTH) ? 2'd2 : 2'd1;
        end else if (req.rw_mode == RW_LATCH) begin
            n = 2'd1;
        end else begin
            n = (req.rw_mode == RW_BOTH) ? 2'd3 : 2'd2;
        end
        return n;
    endfunction

    // Describe access number idx of a request; writes lead with the control byte
    function automatic pit_acc_t acc_desc(input pit_req_t req, input logic [IDX_W-1:0] idx);
        pit_acc_t         acc;
        logic [IDX_W-1:0] j;
        acc     = '0;
        j       = req.op ? idx : idx - 2'd1;
        acc.msb = (req.rw_mode == RW_MSB) || ((req.rw_mode == RW_BOTH) && (j == 2'd1));
        if (!req.op && (idx == 2'd0)) begin
            acc.write = 1'b1;
            acc.addr  = A_CTRL;
            acc.data  = {req.sel, req.rw_mode, req.mode, req.bcd};
        end else begin
            acc.write = !req.op;
            acc.addr  = req.sel;
            acc.data  = req.op ? 8'h00 : (acc.msb ? req.count[15:8] : req.count[7:0]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/pit_bus_cycle.sv
// Single-access bus timing: strobe-length counter, registered bus pins, read capture.
module pit_bus_cycle
    import pit_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pit_state_e  state_q,
    input  pit_state_e  state_d,
    input  logic        acc_write,
    input  logic [1:0]  acc_addr,
    input  logic [7:0]  acc_data,
    input  logic [7:0]  d_in,
    output logic        cs,
    output logic        rd,
    output logic        wr,
    output logic        a1,
    output logic        a0,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic [7:0]  rbyte,
    output logic        strobe_last_c
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] strobe_cnt_q;
    logic             write_q;
    logic [1:0]       addr_q;
    logic             in_acc_c;
    logic             cur_write_c;

    assign strobe_last_c = (state_q == STROBE) &&
                           (strobe_cnt_q == CNT_W'(STROBE_CYCLES - 1));
    assign in_acc_c      = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    assign cur_write_c   = (state_d == SETUP) ? acc_write : write_q;
    assign a1            = addr_q[1];
    assign a0            = addr_q[0];

    // Count cycles spent in STROBE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_cnt_q <= '0;
        end else if ((state_q == STROBE) && !strobe_last_c) begin
            strobe_cnt_q <= strobe_cnt_q + CNT_W'(1);
        end else begin
            strobe_cnt_q <= '0;
        end
    end

    // Bus pins registered from the upcoming state; access fields latched on entry to SETUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs      <= 1'b1;
            rd      <= 1'b1;
            wr      <= 1'b1;
            d_oe    <= 1'b0;
            d_out   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            rbyte   <= '0;
        end else begin
            cs   <= !in_acc_c;
            rd   <= !((state_d == STROBE) && !cur_write_c);
            wr   <= !((state_d == STROBE) && cur_write_c);
            d_oe <= in_acc_c && cur_write_c;
            if (state_d == SETUP) begin
                write_q <= acc_write;
                addr_q  <= acc_addr;
                d_out   <= acc_data;
            end else if (state_d == IDLE) begin
                addr_q <= 2'b00;
            end
            if (strobe_last_c && !write_q) begin
                rbyte <= d_in;
            end
        end
    end

endmodule

// File: rtl/pit_bus_master.sv
// 8254-style PIT bus master: turns one request into control/count writes or count reads.
module pit_bus_master
    import pit_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        op,
    input  logic [1:0]  sel,
    input  logic [1:0]  rw_mode,
    input  logic [2:0]  mode,
    input  logic        bcd,
    input  logic [15:0] count,
    output logic        CS,
    output logic        RD,
    output logic        WR,
    output logic        A1,
    output logic        A0,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] rd_data
);

    pit_state_e         state_q;
    pit_state_e         state_d;
    pit_req_t           req_q;
    pit_req_t           req_in_c;
    pit_acc_t           acc_c;
    logic [IDX_W-1:0]   idx_q;
    logic               accept_c;
    logic               illegal_c;
    logic               last_acc_c;
    logic               strobe_last_c;
    logic [7:0]         rbyte;
    logic [COUNT_W-1:0] rd_stage_q;
    logic [COUNT_W-1:0] rd_stage_c;
    logic               busy_d;
    logic               done_d;
    logic               error_d;

    assign req_in_c   = {op, sel, rw_mode, mode, bcd, count};
    assign accept_c   = (state_q == IDLE) && start;
    assign illegal_c  = (sel == 2'b11) || (op && (rw_mode == RW_LATCH));
    assign last_acc_c = (idx_q == (acc_total(req_q) - 2'd1));
    // In IDLE the first access is taken straight from the inputs being accepted
    assign acc_c      = (state_q == IDLE) ? acc_desc(req_in_c, 2'd0) : acc_desc(req_q, idx_q);

    // Next state and next values of the status outputs
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE:    if (start && !illegal_c) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (strobe_last_c) state_d = HOLD;
            HOLD:    state_d = last_acc_c ? FINISH : GAP;
            GAP:     state_d = SETUP;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD) || (state_d == GAP);
        done_d  = (state_d == FINISH);
        error_d = accept_c && illegal_c;
    end

    // Assemble read bytes; the byte not read stays zero
    always_comb begin
        rd_stage_c = rd_stage_q;
        if (accept_c) begin
            rd_stage_c = '0;
        end else if ((state_q == HOLD) && req_q.op) begin
            if (acc_c.msb) begin
                rd_stage_c[15:8] = rbyte;
            end else begin
                rd_stage_c[7:0] = rbyte;
            end
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture and access index
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_q      <= '0;
            idx_q      <= '0;
            rd_stage_q <= '0;
        end else begin
            if (accept_c) begin
                req_q <= req_in_c;
                idx_q <= '0;
            end else if ((state_q == HOLD) && !last_acc_c) begin
                idx_q <= idx_q + 2'd1;
            end
            rd_stage_q <= rd_stage_c;
        end
    end

    // Registered status outputs; rd_data only moves when a read completes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            rd_data <= '0;
        end else begin
            busy  <= busy_d;
            done  <= done_d;
            error <= error_d;
            if ((state_q == HOLD) && last_acc_c && req_q.op) begin
                rd_data <= rd_stage_c;
            end
        end
    end

    pit_bus_cycle #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_bus_cycle (
        .clk           (CLK),
        .rst_n         (RST_N),
        .state_q       (state_q),
        .state_d       (state_d),
        .acc_write     (acc_c.write),
        .acc_addr      (acc_c.addr),
        .acc_data      (acc_c.data),
        .d_in          (D_in),
        .cs            (CS),
        .rd            (RD),
        .wr            (WR),
        .a1            (A1),
        .a0            (A0),
        .d_out         (D_out),
        .d_oe          (D_oe),
        .rbyte         (rbyte),
        .strobe_last_c (strobe_last_c)
    );

endmodule

// File: tb/tb_pit_bus_master.sv
// Randomized self-checking bench for pit_bus_master with a cycle-arithmetic bus model.
module tb_pit_bus_master;

    localparam int S = 2;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic        op;
    logic [1:0]  sel;
    logic [1:0]  rw_mode;
    logic [2:0]  mode;
    logic        bcd;
    logic [15:0] count;
    logic        CS;
    logic        RD;
    logic        WR;
    logic        A1;
    logic        A0;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] rd_data;

    int          checks;
    int          errors;
    logic [15:0] exp_rd;

    pit_bus_master #(
        .STROBE_CYCLES(S)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .start   (start),
        .op      (op),
        .sel     (sel),
        .rw_mode (rw_mode),
        .mode    (mode),
        .bcd     (bcd),
        .count   (count),
        .CS      (CS),
        .RD      (RD),
        .WR      (WR),
        .A1      (A1),
        .A0      (A0),
        .D_out   (D_out),
        .D_oe    (D_oe),
        .D_in    (D_in),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .rd_data (rd_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scramble request inputs; the DUT must have registered them already
    task automatic scramble_inputs();
        op      = 1'($urandom);
        sel     = 2'($urandom);
        rw_mode = 2'($urandom);
        mode    = 3'($urandom);
        bcd     = 1'($urandom);
        count   = 16'($urandom);
    endtask

    // Check that the bus is quiet and nothing is in progress
    task automatic check_idle(input string name);
        logic [6:0] got;
        got = {CS, RD, WR, D_oe, busy, done, error};
        checks++;
        if (got !== 7'b1110000) begin
            errors++;
            $display("FAIL %s idle {CS,RD,WR,D_oe,busy,done,error} got=%b exp=1110000", name, got);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        checks++;
        if ({CS, RD, WR, A1, A0, D_oe, busy, done, error} !== 9'b111000000 ||
            D_out !== 8'h00 || rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset pins=%b D_out=%h rd_data=%h exp pins=111000000 D_out=00 rd_data=0000",
                     {CS, RD, WR, A1, A0, D_oe, busy, done, error}, D_out, rd_data);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_idle("reset_release");
    endtask

    // Issue one legal request and check every cycle until done
    task automatic run_req(input bit r_op, input bit [1:0] r_sel, input bit [1:0] r_rw,
                           input bit [2:0] r_mode, input bit r_bcd, input bit [15:0] r_cnt,
                           input bit [7:0] lo_b, input bit [7:0] hi_b, input bit keep,
                           input string name);
        bit         aw[3];
        bit [1:0]   aa[3];
        bit [7:0]   ad[3];
        bit         am[3];
        int         n;
        int         tb;
        int         k;
        int         p;
        int         busy_cyc;
        int         done_cnt;
        logic [6:0] got;
        logic [6:0] e_pins;
        n = 0;
        if (!r_op) begin
            aw[n] = 1'b1; aa[n] = 2'b11; ad[n] = {r_sel, r_rw, r_mode, r_bcd}; am[n] = 1'b0; n++;
        end
        if (r_rw[0]) begin
            aw[n] = !r_op; aa[n] = r_sel; ad[n] = r_cnt[7:0]; am[n] = 1'b0; n++;
        end
        if (r_rw[1]) begin
            aw[n] = !r_op; aa[n] = r_sel; ad[n] = r_cnt[15:8]; am[n] = 1'b1; n++;
        end
        if (r_op) exp_rd = {r_rw[1] ? hi_b : 8'h00, r_rw[0] ? lo_b : 8'h00};
        tb       = (S + 3) * n - 1;
        busy_cyc = 0;
        done_cnt = 0;

        @(negedge CLK);
        check_idle({name, "_pre"});
        start = 1'b1; op = r_op; sel = r_sel; rw_mode = r_rw;
        mode = r_mode; bcd = r_bcd; count = r_cnt;
        D_in = 8'($urandom);

        for (int t = 1; t <= tb + 1; t++) begin
            @(negedge CLK);
            if (t == 1) begin
                scramble_inputs();
                start = keep;
            end
            k = (t <= tb) ? (t - 1) / (S + 3) : 0;
            p = (t - 1) % (S + 3);
            if (t <= tb) begin
                e_pins = {(p <= S + 1) ? 1'b0 : 1'b1,
                          (!aw[k] && p >= 1 && p <= S) ? 1'b0 : 1'b1,
                          (aw[k] && p >= 1 && p <= S) ? 1'b0 : 1'b1,
                          (aw[k] && p <= S + 1) ? 1'b1 : 1'b0,
                          3'b100};
            end else begin
                e_pins = 7'b1110010;
            end
            got = {CS, RD, WR, D_oe, busy, done, error};
            busy_cyc += busy ? 1 : 0;
            done_cnt += done ? 1 : 0;
            checks++;
            if (got !== e_pins) begin
                errors++;
                $display("FAIL %s t=%0d {CS,RD,WR,D_oe,busy,done,error} got=%b exp=%b",
                         name, t, got, e_pins);
            end
            if (t <= tb && p <= S + 1) begin
                checks++;
                if ({A1, A0} !== aa[k]) begin
                    errors++;
                    $display("FAIL %s t=%0d addr got=%b exp=%b", name, t, {A1, A0}, aa[k]);
                end
                if (aw[k]) begin
                    checks++;
                    if (D_out !== ad[k]) begin
                        errors++;
                        $display("FAIL %s t=%0d D_out got=%h exp=%h", name, t, D_out, ad[k]);
                    end
                end
            end
            if (t == tb + 1) begin
                checks++;
                if (rd_data !== exp_rd) begin
                    errors++;
                    $display("FAIL %s rd_data got=%h exp=%h", name, rd_data, exp_rd);
                end
            end
            // Valid read data only in the last strobe cycle; junk elsewhere
            if (t <= tb && !aw[k] && p == S) D_in = am[k] ? hi_b : lo_b;
            else D_in = 8'($urandom);
        end
        checks++;
        if (busy_cyc != 4 * n + (n - 1) || done_cnt != 1) begin
            errors++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d done_pulses got=%0d exp=1",
                     name, busy_cyc, 4 * n + (n - 1), done_cnt);
        end
    endtask

    task automatic test_write_both();
        run_req(1'b0, 2'd1, 2'b11, 3'd3, 1'b0, 16'h1234, 8'h00, 8'h00, 1'b0, "write_both");
    endtask

    task automatic test_read_both();
        run_req(1'b1, 2'd2, 2'b11, 3'($urandom), 1'($urandom), 16'($urandom),
                8'hCD, 8'hAB, 1'b0, "read_both");
        checks++;
        if (rd_data !== 16'hABCD) begin
            errors++;
            $display("FAIL read_both_value rd_data got=%h exp=abcd", rd_data);
        end
    endtask

    task automatic test_latch();
        run_req(1'b0, 2'd0, 2'b00, 3'd0, 1'b0, 16'($urandom), 8'h00, 8'h00, 1'b0, "latch");
    endtask

    // Illegal request: one error pulse, no bus activity, no done
    task automatic test_error(input bit e_op, input bit [1:0] e_sel, input bit [1:0] e_rw,
                              input string name);
        logic [6:0] got;
        @(negedge CLK);
        check_idle({name, "_pre"});
        start = 1'b1; op = e_op; sel = e_sel; rw_mode = e_rw;
        mode = 3'($urandom); bcd = 1'($urandom); count = 16'($urandom);
        for (int t = 1; t <= 4; t++) begin
            @(negedge CLK);
            if (t == 1) start = 1'b0;
            got = {CS, RD, WR, D_oe, busy, done, error};
            checks++;
            if (got !== {6'b111000, (t == 1)}) begin
                errors++;
                $display("FAIL %s t=%0d {CS,RD,WR,D_oe,busy,done,error} got=%b exp=%b",
                         name, t, got, {6'b111000, (t == 1)});
            end
        end
        checks++;
        if (rd_data !== exp_rd) begin
            errors++;
            $display("FAIL %s rd_data got=%h exp=%h", name, rd_data, exp_rd);
        end
    endtask

    // Reset asserted in the strobe of the second write access
    task automatic test_reset_mid();
        @(negedge CLK);
        check_idle("reset_mid_pre");
        start = 1'b1; op = 1'b0; sel = 2'($urandom_range(0, 2)); rw_mode = 2'b11;
        mode = 3'($urandom); bcd = 1'($urandom); count = 16'($urandom);
        for (int t = 1; t <= S + 5; t++) begin
            @(negedge CLK);
            if (t == 1) start = 1'b0;
        end
        checks++;
        if ({CS, WR} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_strobe {CS,WR} got=%b exp=00", {CS, WR});
        end
        #1;
        RST_N = 1'b0;
        #1;
        exp_rd = 16'h0000;
        checks++;
        if ({CS, RD, WR, A1, A0, D_oe, busy, done, error} !== 9'b111000000 ||
            D_out !== 8'h00 || rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_async pins=%b D_out=%h rd_data=%h exp pins=111000000 D_out=00 rd_data=0000",
                     {CS, RD, WR, A1, A0, D_oe, busy, done, error}, D_out, rd_data);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge CLK);
            check_idle("reset_mid_after");
        end
        run_req(1'b0, 2'd2, 2'b01, 3'd2, 1'b1, 16'hBEEF, 8'h00, 8'h00, 1'b0, "reset_mid_new");
    endtask

    // start held high across several requests
    task automatic test_back_to_back();
        run_req(1'b0, 2'd0, 2'b11, 3'd5, 1'b1, 16'($urandom), 8'h00, 8'h00, 1'b1, "b2b_0");
        run_req(1'b1, 2'd1, 2'b01, 3'd0, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom), 1'b1, "b2b_1");
        run_req(1'b1, 2'd0, 2'b10, 3'd4, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom), 1'b0, "b2b_2");
    endtask

    task automatic test_random();
        bit       r_op;
        bit [1:0] r_rw;
        for (int i = 0; i < 24; i++) begin
            r_op = 1'($urandom);
            r_rw = r_op ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
            run_req(r_op, 2'($urandom_range(0, 2)), r_rw, 3'($urandom), 1'($urandom),
                    16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                    "random");
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_rd  = 16'h0000;
        start   = 1'b0;
        op      = 1'b0;
        sel     = 2'b00;
        rw_mode = 2'b00;
        mode    = 3'b000;
        bcd     = 1'b0;
        count   = 16'h0000;
        D_in    = 8'h00;
        RST_N   = 1'b0;

        test_reset();
        test_write_both();
        test_read_both();
        test_latch();
        test_error(1'($urandom), 2'b11, 2'($urandom), "error_sel3");
        test_error(1'b1, 2'd1, 2'b00, "error_read_latch");
        test_reset_mid();
        test_back_to_back();
        test_random();
        start = 1'b0;
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
